bcd_seg7_scan: RTL and testbench
================================

Name: bcd_seg7_scan

Overview:
- Downstream display stage for the 8-bit BCD counter.
- Takes the counter's 2-digit packed BCD value and drives a time-multiplexed 2-digit seven-segment display.
- A shadow/display register pair prevents tearing: new values reach the digits only at frame boundaries.
- Scan sequencing: a refresh prescaler and state machine scan units then tens, with an anti-ghosting blank interval before each digit.

Parameters:
- PERIOD, 1000: clock cycles per digit slot (>= BLANK_CYC+2).
- BLANK_CYC, 16: cycles at the start of each slot with all digits off (>= 1).
- LZ_BLANK, 1: 1 = tens digit blank when it is 0.
- ACTIVE_LOW, 0: 1 = o_seg and o_dig inverted (common-anode). Inactive level is then all ones.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous reset, active-high.
- i_bcd  in  8  packed BCD value; [7:4] tens, [3:0] units.
- i_load  in  1  capture strobe for i_bcd.
- i_en  in  1  display enable.
- o_seg  out  7  segments, bit0=a .. bit6=g.
- o_dig  out  2  one-hot digit enable; bit0 units, bit1 tens.
- o_frame  out  1  one-cycle pulse when the display register updates at a frame boundary.

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset state:
  - state=IDLE, cnt=0, ptr=0 (units).
  - shadow=0, disp=0.
  - o_seg and o_dig at inactive level (0, or all ones if ACTIVE_LOW).
  - o_frame=0.
- Shadow register: i_load=1 captures i_bcd into shadow at the next edge. It is never blocked.
- States: IDLE, BLANK, SHOW.
  - IDLE: disp<=shadow every cycle. If i_load=1 the same cycle, disp<=i_bcd directly. If i_en=1: go to BLANK with cnt=0, ptr=0.
  - BLANK: cnt increments. When cnt==BLANK_CYC-1, go to SHOW.
  - SHOW: cnt increments. When cnt==PERIOD-1: cnt<=0, ptr<=~ptr, go to BLANK.
  - Any state with i_en=0: go to IDLE next edge, cnt<=0, ptr<=0.
- Counter width: $clog2(PERIOD). cnt never exceeds PERIOD-1.
- Frame boundary: SHOW && cnt==PERIOD-1 && ptr==1.
  - At the boundary: disp<=shadow. If i_load coincides, disp<=i_bcd (bypass).
  - o_frame is registered: high exactly one cycle after the boundary edge. This is the first cycle disp holds the new value.
  - i_load at any other time in BLANK/SHOW changes only shadow. The visible digits do not change mid-frame.
- Outputs are registered, one cycle latency from state/ptr/disp:
  - o_dig: 01 when state==SHOW && ptr==0; 10 when state==SHOW && ptr==1; else 00.
  - o_seg: decode of disp nibble[ptr] when in SHOW, else 0.
  - Segment map (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F.
  - Invalid nibble A-F: 40 (dash, g only).
  - Leading zero, LZ_BLANK=1 and tens nibble==0: o_seg=00 while o_dig=10. The digit is still scanned so duty cycle stays constant.
  - ACTIVE_LOW=1: bitwise invert o_seg and o_dig after all of the above. o_frame is never inverted.
- Reset mid-operation: all state returns to reset values at the next edge, whatever i_en and i_load are doing.
- Re-enable after disable: always restarts at units BLANK, cnt=0.

Test Plan:
- Bench parameters: PERIOD=8, BLANK_CYC=2.
- Reset: assert i_rst 4 cycles with i_en=1, i_load=1 -> o_seg=00, o_dig=00, o_frame=0 throughout; shadow/disp=00 after release.
- Basic scan: in IDLE load 0x42, then i_en=1 -> 2 cycles o_dig=00, then 6 cycles o_dig=01 with o_seg=5B; 2 cycles 00/00, then 6 cycles o_dig=10 with o_seg=66; o_frame pulses once, 1 cycle after the tens slot ends; the sequence repeats.
- Leading zero / invalid digit:
  - Load 0x07 -> units 07, tens slot o_dig=10 with o_seg=00.
  - LZ_BLANK=0 -> tens slot o_seg=3F.
  - Load 0x3C -> units 40, tens 4F.
- No tearing: while 0x42 is in the units SHOW slot, pulse i_load with 0x11 -> tens still shows 66; o_frame pulses; the next units slot shows 06 and tens shows 06. Also check a load on the boundary cycle itself -> the new value appears right after o_frame.
- Disable / re-enable: drop i_en mid tens-SHOW -> o_dig=00 within 2 edges, no o_frame; raise i_en -> restart with 2 blank cycles, then units (o_dig=01).
- ACTIVE_LOW=1: repeat the basic scan -> blank cycles show o_seg=7F, o_dig=11; units slot shows o_dig=10, o_seg=24; o_frame is unchanged.

Source files
------------

// File: rtl/bcd_seg7_scan_if.sv
// bcd_seg7_scan_if: BCD value in, scanned seven-segment drive out.
// master drives i_bcd/i_load/i_en; slave (display) drives o_seg/o_dig/o_frame.
interface bcd_seg7_scan_if;
  logic [7:0] i_bcd;
  logic       i_load;
  logic       i_en;
  logic [6:0] o_seg;
  logic [1:0] o_dig;
  logic       o_frame;

  modport master (
    output i_bcd, i_load, i_en,
    input  o_seg, o_dig, o_frame
  );

  modport slave (
    input  i_bcd, i_load, i_en,
    output o_seg, o_dig, o_frame
  );
endinterface

// File: rtl/bcd_seg7_scan.sv
// bcd_seg7_scan: 2-digit multiplexed 7-seg driver, tear-free frame update.
// Ports: i_clk, i_rst (sync, high), bus = i_bcd/i_load/i_en -> o_seg/o_dig/o_frame.
module bcd_seg7_scan #(
  parameter int PERIOD     = 1000,
  parameter int BLANK_CYC  = 16,
  parameter int LZ_BLANK   = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  bcd_seg7_scan_if.slave bus
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0] LAST_SLOT  = CW'(PERIOD - 1);
  localparam logic INV = (ACTIVE_LOW != 0);
  localparam logic LZ  = (LZ_BLANK != 0);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          ptr;
  logic [7:0]    shadow;
  logic [7:0]    disp;

  logic       slot_end;
  logic       boundary;
  logic [7:0] next_disp;
  logic [3:0] nib;
  logic [6:0] seg_n;
  logic [1:0] dig_n;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: seg_of = 7'h3F;
      4'h1: seg_of = 7'h06;
      4'h2: seg_of = 7'h5B;
      4'h3: seg_of = 7'h4F;
      4'h4: seg_of = 7'h66;
      4'h5: seg_of = 7'h6D;
      4'h6: seg_of = 7'h7D;
      4'h7: seg_of = 7'h07;
      4'h8: seg_of = 7'h7F;
      4'h9: seg_of = 7'h6F;
      default: seg_of = 7'h40;
    endcase
  endfunction

  assign slot_end  = (state == SHOW) && (cnt == LAST_SLOT);
  assign boundary  = slot_end && ptr;
  // a load coinciding with a disp update bypasses the shadow
  assign next_disp = bus.i_load ? bus.i_bcd : shadow;
  assign nib       = ptr ? disp[7:4] : disp[3:0];

  always_comb begin
    dig_n = 2'b00;
    seg_n = 7'h00;
    if (state == SHOW) begin
      dig_n = ptr ? 2'b10 : 2'b01;
      seg_n = seg_of(nib);
      // blanked leading zero is still scanned to keep duty constant
      if (ptr && LZ && disp[7:4] == 4'h0)
        seg_n = 7'h00;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ptr         <= 1'b0;
      shadow      <= 8'h00;
      disp        <= 8'h00;
      bus.o_seg   <= {7{INV}};
      bus.o_dig   <= {2{INV}};
      bus.o_frame <= 1'b0;
    end else begin
      bus.o_seg   <= seg_n ^ {7{INV}};
      bus.o_dig   <= dig_n ^ {2{INV}};
      bus.o_frame <= 1'b0;
      if (bus.i_load)
        shadow <= bus.i_bcd;
      if (state == IDLE)
        disp <= next_disp;
      if (!bus.i_en) begin
        state <= IDLE;
        cnt   <= '0;
        ptr   <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            state <= BLANK;
            cnt   <= '0;
            ptr   <= 1'b0;
          end
          BLANK: begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BLANK)
              state <= SHOW;
          end
          SHOW: begin
            if (slot_end) begin
              cnt   <= '0;
              ptr   <= ~ptr;
              state <= BLANK;
            end else begin
              cnt <= cnt + 1'b1;
            end
            if (boundary) begin
              disp        <= next_disp;
              bus.o_frame <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bcd_seg7_scan.sv
// tb_bcd_seg7_scan: three display variants driven in lockstep,
// checked every cycle against a slot-position model plus literal vectors.
module tb_bcd_seg7_scan;
  localparam int P = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] bcd = 8'h99;
  logic       load = 1'b1;
  logic       en = 1'b1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_seg7_scan_if b0 ();
  bcd_seg7_scan_if b1 ();
  bcd_seg7_scan_if b2 ();

  assign b0.i_bcd = bcd;
  assign b0.i_load = load;
  assign b0.i_en = en;
  assign b1.i_bcd = bcd;
  assign b1.i_load = load;
  assign b1.i_en = en;
  assign b2.i_bcd = bcd;
  assign b2.i_load = load;
  assign b2.i_en = en;

  bcd_seg7_scan #(
    .PERIOD(P), .BLANK_CYC(B), .LZ_BLANK(1), .ACTIVE_LOW(0)
  ) d0 (.i_clk(clk), .i_rst(rst), .bus(b0));

  bcd_seg7_scan #(
    .PERIOD(P), .BLANK_CYC(B), .LZ_BLANK(0), .ACTIVE_LOW(0)
  ) d1 (.i_clk(clk), .i_rst(rst), .bus(b1));

  bcd_seg7_scan #(
    .PERIOD(P), .BLANK_CYC(B), .LZ_BLANK(1), .ACTIVE_LOW(1)
  ) d2 (.i_clk(clk), .i_rst(rst), .bus(b2));

  logic [6:0] segtab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40
  };

  // model: age = cycles since the scan left idle, modulo one frame
  bit         act = 0;
  int         age = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] dv = 8'h00;
  bit         e_show = 0;
  bit         e_slot = 0;
  bit         e_frame = 0;
  logic [7:0] e_dv = 8'h00;
  bit         started = 0;

  always @(posedge clk) begin
    bit         bnd;
    logic [7:0] nd;
    started = 1;
    if (rst) begin
      act = 0; age = 0; sh = 8'h00; dv = 8'h00;
      e_show = 0; e_slot = 0; e_frame = 0; e_dv = 8'h00;
    end else begin
      e_show = act && ((age % P) >= B);
      e_slot = act && (age >= P);
      e_dv = dv;
      bnd = act && en && (age == 2 * P - 1);
      e_frame = bnd;
      nd = load ? bcd : sh;
      if (!act || bnd) dv = nd;
      if (load) sh = bcd;
      if (!en) begin
        act = 0; age = 0;
      end else if (!act) begin
        act = 1; age = 0;
      end else begin
        age = (age + 1) % (2 * P);
      end
    end
  end

  function automatic logic [8:0] exp_out(bit lz, bit al);
    logic [6:0] s;
    logic [1:0] d;
    logic [3:0] n;
    s = 7'h00;
    d = 2'b00;
    if (e_show) begin
      d = e_slot ? 2'b10 : 2'b01;
      n = e_slot ? e_dv[7:4] : e_dv[3:0];
      s = segtab[n];
      if (e_slot && lz && n == 4'h0) s = 7'h00;
    end
    if (al) begin
      s = ~s;
      d = ~d;
    end
    return {d, s};
  endfunction

  task automatic chk(input string nm, input logic [9:0] act_v,
                     input logic [9:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, act_v, exp_v, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("model_d0", {b0.o_dig, b0.o_seg, b0.o_frame},
          {exp_out(1, 0), e_frame});
      chk("model_d1", {b1.o_dig, b1.o_seg, b1.o_frame},
          {exp_out(0, 0), e_frame});
      chk("model_d2", {b2.o_dig, b2.o_seg, b2.o_frame},
          {exp_out(1, 1), e_frame});
    end
  end

  task automatic wait_dig(input logic [1:0] d);
    int n = 0;
    while (b0.o_dig !== d && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_dig", {8'h0, b0.o_dig}, {8'h0, d});
  endtask

  task automatic wait_frame();
    int n = 0;
    while (b0.o_frame !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_frame", {9'h0, b0.o_frame}, 10'h1);
  endtask

  task automatic run_len(output int len, output int fr);
    logic [1:0] d;
    d = b0.o_dig;
    len = 0;
    fr = 0;
    while (b0.o_dig === d && len < 50) begin
      if (b0.o_frame) fr++;
      len++;
      @(negedge clk);
    end
  endtask

  initial begin
    int len;
    int fr;
    int frs;
    repeat (4) @(negedge clk);
    chk("rst_seg", {3'h0, b0.o_seg}, 10'h000);
    chk("rst_dig", {8'h0, b0.o_dig}, 10'h000);
    chk("rst_frame", {9'h0, b0.o_frame}, 10'h000);
    chk("rst_al", {1'b0, b2.o_dig, b2.o_seg}, {1'b0, 2'b11, 7'h7F});
    rst = 1'b0;
    load = 1'b0;

    wait_dig(2'b01);
    chk("zero_units", {3'h0, b0.o_seg}, {3'h0, 7'h3F});
    wait_dig(2'b10);
    chk("zero_tens_lz", {3'h0, b0.o_seg}, 10'h000);
    chk("zero_tens_nolz", {3'h0, b1.o_seg}, {3'h0, 7'h3F});

    en = 1'b0;
    bcd = 8'h42;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_dig", {8'h0, b0.o_dig}, 10'h000);

    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("start_blank", {8'h0, b0.o_dig}, 10'h000);
      chk("start_blank_al", {1'b0, b2.o_dig, b2.o_seg},
          {1'b0, 2'b11, 7'h7F});
    end
    @(negedge clk);
    chk("units_dig", {8'h0, b0.o_dig}, {8'h0, 2'b01});
    chk("units_seg", {3'h0, b0.o_seg}, {3'h0, 7'h5B});
    chk("units_al", {1'b0, b2.o_dig, b2.o_seg}, {1'b0, 2'b10, 7'h24});
    frs = 0;
    run_len(len, fr);
    frs += fr;
    chk("units_len", 10'(len), 10'd6);
    run_len(len, fr);
    frs += fr;
    chk("blank_len", 10'(len), 10'd2);
    chk("tens_seg", {3'h0, b0.o_seg}, {3'h0, 7'h66});
    chk("tens_al", {1'b0, b2.o_dig, b2.o_seg}, {1'b0, 2'b01, 7'h19});
    run_len(len, fr);
    frs += fr;
    chk("tens_len", 10'(len), 10'd6);
    chk("frame_count", 10'(frs), 10'd1);

    wait_dig(2'b01);
    bcd = 8'h11;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_dig(2'b10);
    chk("no_tear_tens", {3'h0, b0.o_seg}, {3'h0, 7'h66});
    wait_frame();
    wait_dig(2'b01);
    chk("new_units", {3'h0, b0.o_seg}, {3'h0, 7'h06});
    wait_dig(2'b10);
    chk("new_tens", {3'h0, b0.o_seg}, {3'h0, 7'h06});

    wait_frame();
    repeat (15) @(negedge clk);
    bcd = 8'h3C;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("bnd_frame", {9'h0, b0.o_frame}, 10'h1);
    wait_dig(2'b01);
    chk("bypass_units", {3'h0, b0.o_seg}, {3'h0, 7'h40});
    wait_dig(2'b10);
    chk("bypass_tens", {3'h0, b0.o_seg}, {3'h0, 7'h4F});

    bcd = 8'h07;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    wait_frame();
    wait_dig(2'b01);
    chk("lz_units", {3'h0, b0.o_seg}, {3'h0, 7'h07});
    wait_dig(2'b10);
    chk("lz_tens", {3'h0, b0.o_seg}, 10'h000);
    chk("nolz_tens", {3'h0, b1.o_seg}, {3'h0, 7'h3F});

    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("dis_dig", {8'h0, b0.o_dig}, 10'h000);
    fr = 0;
    for (int i = 0; i < 6; i++) begin
      if (b0.o_frame) fr++;
      @(negedge clk);
    end
    chk("dis_frame", 10'(fr), 10'd0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("re_blank", {8'h0, b0.o_dig}, 10'h000);
    end
    @(negedge clk);
    chk("re_units", {8'h0, b0.o_dig}, {8'h0, 2'b01});
    chk("re_seg", {3'h0, b0.o_seg}, {3'h0, 7'h07});

    repeat (3) @(negedge clk);
    rst = 1'b1;
    bcd = 8'h55;
    load = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    load = 1'b0;
    chk("mid_rst_dig", {8'h0, b0.o_dig}, 10'h000);
    chk("mid_rst_al", {1'b0, b2.o_dig, b2.o_seg}, {1'b0, 2'b11, 7'h7F});
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
